// File: rtl/snake_master_fsm.sv
// rtl/snake_master_fsm.sv - master game sequencer: game state, score, move tick pacing and target requests
module snake_master_fsm #(
    parameter int WIN_SCORE = 10,
    parameter int TICK_W    = 24,
    parameter int TICK_BASE = 5_000_000,
    parameter int TICK_STEP = 250_000,
    parameter int TICK_MIN  = 1_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       REACHED,
    input  logic       HIT,
    input  logic       TARGET_ACK,
    output logic [1:0] M_STATE,
    output logic [3:0] SCORE,
    output logic       MOVE_TICK,
    output logic       TARGET_REQ
);
    localparam int PW = TICK_W + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    state_t            state_q;
    logic [3:0]        score_q;
    logic [TICK_W-1:0] cnt_q;
    logic              move_tick_q;
    logic              target_req_q;
    logic              start_prev_q;

    logic              start_rise;
    logic [3:0]        score_inc;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     period;
    logic [PW-1:0]     last_cnt;
    logic [PW-1:0]     cnt_ext;
    logic              tick_hit;
    logic              cnt_over;

    assign start_rise = START & ~start_prev_q;
    assign score_inc  = score_q + 4'd1;

    // Period shrinks with score; the clamp test runs on the product so the subtraction never wraps.
    always_comb begin
        prod = PW'(score_q) * PW'(TICK_STEP);
        if (prod >= PW'(TICK_BASE - TICK_MIN)) begin
            period = PW'(TICK_MIN);
        end else begin
            period = PW'(TICK_BASE) - prod;
        end
        last_cnt = period - PW'(1);
        cnt_ext  = PW'(cnt_q);
        tick_hit = (cnt_ext == last_cnt);
        cnt_over = (cnt_ext > last_cnt);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            score_q      <= '0;
            cnt_q        <= '0;
            move_tick_q  <= 1'b0;
            target_req_q <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            start_prev_q <= START;
            move_tick_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start_rise) begin
                        state_q      <= S_PLAY;
                        score_q      <= '0;
                        target_req_q <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (HIT) begin
                        state_q      <= S_LOSE;
                        target_req_q <= 1'b0;
                        cnt_q        <= '0;
                    end else begin
                        if (tick_hit) begin
                            move_tick_q <= 1'b1;
                            cnt_q       <= '0;
                        end else if (cnt_over) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + TICK_W'(1);
                        end
                        if (target_req_q && TARGET_ACK) begin
                            target_req_q <= 1'b0;
                        end
                        // A pending request masks REACHED, so one target can only score once.
                        if (REACHED && !target_req_q) begin
                            score_q <= score_inc;
                            if (score_inc == 4'(WIN_SCORE)) begin
                                state_q      <= S_WIN;
                                target_req_q <= 1'b0;
                                move_tick_q  <= 1'b0;
                                cnt_q        <= '0;
                            end else begin
                                target_req_q <= 1'b1;
                            end
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    cnt_q        <= '0;
                    target_req_q <= 1'b0;
                    if (start_rise) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign M_STATE    = state_q;
    assign SCORE      = score_q;
    assign MOVE_TICK  = move_tick_q;
    assign TARGET_REQ = target_req_q;

endmodule

// File: tb/tb_snake_master_fsm.sv
// tb/tb_snake_master_fsm.sv - self-checking bench for snake_master_fsm against a behavioural game model
module tb_snake_master_fsm;
    localparam int WIN  = 3;
    localparam int BASE = 10;
    localparam int STEP = 3;
    localparam int TMIN = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       REACHED = 1'b0;
    logic       HIT = 1'b0;
    logic       TARGET_ACK = 1'b0;
    logic [1:0] M_STATE;
    logic [3:0] SCORE;
    logic       MOVE_TICK;
    logic       TARGET_REQ;

    int checks = 0;
    int fails  = 0;

    // Behavioural model: 0 idle, 1 play, 2 win, 3 lose; m_age = cycles since the pacing count restarted.
    int m_state = 0;
    int m_score = 0;
    int m_age   = 0;
    bit m_tick  = 0;
    bit m_req   = 0;
    bit m_prev  = 1;

    snake_master_fsm #(
        .WIN_SCORE(WIN),
        .TICK_W   (8),
        .TICK_BASE(BASE),
        .TICK_STEP(STEP),
        .TICK_MIN (TMIN)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .REACHED   (REACHED),
        .HIT       (HIT),
        .TARGET_ACK(TARGET_ACK),
        .M_STATE   (M_STATE),
        .SCORE     (SCORE),
        .MOVE_TICK (MOVE_TICK),
        .TARGET_REQ(TARGET_REQ)
    );

    always #5 CLK = ~CLK;

    function automatic int period_of(int s);
        int p;
        p = BASE - s * STEP;
        return (p < TMIN) ? TMIN : p;
    endfunction

    task automatic model_step();
        bit rise;
        bit req_was;
        int p;
        rise    = START && !m_prev;
        m_prev  = START;
        m_tick  = 0;
        req_was = m_req;
        if (RESET) begin
            m_state = 0; m_score = 0; m_age = 0; m_req = 0; m_prev = 1;
            return;
        end
        case (m_state)
            0: begin
                m_age = 0;
                if (rise) begin m_state = 1; m_score = 0; m_req = 1; end
            end
            1: begin
                if (HIT) begin
                    m_state = 3; m_req = 0; m_age = 0;
                end else begin
                    p = period_of(m_score);
                    if (m_age == p - 1) begin m_tick = 1; m_age = 0; end
                    else if (m_age >= p) m_age = 0;
                    else m_age++;
                    if (req_was && TARGET_ACK) m_req = 0;
                    if (REACHED && !req_was) begin
                        m_score++;
                        if (m_score == WIN) begin m_state = 2; m_req = 0; m_tick = 0; m_age = 0; end
                        else m_req = 1;
                    end
                end
            end
            default: begin
                m_age = 0; m_req = 0;
                if (rise) m_state = 0;
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic press();
        START = 1'b1;
        cycle();
        START = 1'b0;
    endtask

    task automatic test_reset();
        START = 1'b1;
        RESET = 1'b1;
        cycle(); cycle();
        checks++;
        if ({M_STATE, SCORE, MOVE_TICK, TARGET_REQ} !== 8'h00) begin
            fails++; $display("FAIL reset_values got %h exp 00", {M_STATE, SCORE, MOVE_TICK, TARGET_REQ});
        end
        RESET = 1'b0;
        cycle(); cycle(); cycle();
        checks++;
        if (M_STATE !== 2'd0) begin
            fails++; $display("FAIL start_held_through_reset state got %0d exp 0", M_STATE);
        end
        START = 1'b0;
        cycle();
        press();
        checks++;
        if (M_STATE !== 2'd1 || TARGET_REQ !== 1'b1 || SCORE !== 4'd0) begin
            fails++; $display("FAIL start_press state=%0d req=%0b score=%0d exp 1/1/0", M_STATE, TARGET_REQ, SCORE);
        end
        cycle(); cycle(); cycle();
        checks++;
        if (TARGET_REQ !== 1'b1) begin
            fails++; $display("FAIL req_held got %0b exp 1", TARGET_REQ);
        end
        TARGET_ACK = 1'b1;
        cycle();
        TARGET_ACK = 1'b0;
        checks++;
        if (TARGET_REQ !== 1'b0) begin
            fails++; $display("FAIL req_ack_drop got %0b exp 0", TARGET_REQ);
        end
    endtask

    task automatic test_tick_pacing();
        int exp_p[3] = '{10, 7, 4};
        int last;
        int gap;
        bit found;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                REACHED = 1'b1; cycle(); REACHED = 1'b0;
                TARGET_ACK = 1'b1; cycle(); TARGET_ACK = 1'b0;
            end
            last = -1; gap = -1; found = 0;
            for (int i = 0; i < 40 && !found; i++) begin
                cycle();
                checks++;
                if (MOVE_TICK !== m_tick) begin
                    fails++; $display("FAIL pacing_tick_model k=%0d i=%0d got %0b exp %0b", k, i, MOVE_TICK, m_tick);
                end
                if (MOVE_TICK === 1'b1) begin
                    if (last >= 0) begin gap = i - last; found = 1; end
                    last = i;
                end
            end
            checks++;
            if (!found || gap != exp_p[k]) begin
                fails++; $display("FAIL pacing_period score=%0d got %0d exp %0d", k, gap, exp_p[k]);
            end
        end
        checks++;
        if (SCORE !== 4'd2) begin
            fails++; $display("FAIL pacing_score got %0d exp 2", SCORE);
        end
    endtask

    task automatic test_win();
        int ticks;
        RESET = 1'b1; cycle(); RESET = 1'b0;
        cycle();
        press();
        for (int k = 1; k <= 3; k++) begin
            TARGET_ACK = 1'b1; cycle(); TARGET_ACK = 1'b0;
            REACHED = 1'b1; cycle(); REACHED = 1'b0;
            checks++;
            if (SCORE !== 4'(k)) begin
                fails++; $display("FAIL win_score_step got %0d exp %0d", SCORE, k);
            end
            checks++;
            if (k < 3 && (M_STATE !== 2'd1 || TARGET_REQ !== 1'b1)) begin
                fails++; $display("FAIL win_midgame state=%0d req=%0b exp 1/1", M_STATE, TARGET_REQ);
            end else if (k == 3 && (M_STATE !== 2'd2 || TARGET_REQ !== 1'b0)) begin
                fails++; $display("FAIL win_reached state=%0d req=%0b exp 2/0", M_STATE, TARGET_REQ);
            end
        end
        ticks = 0;
        for (int i = 0; i < 20; i++) begin cycle(); if (MOVE_TICK === 1'b1) ticks++; end
        checks++;
        if (ticks != 0 || M_STATE !== 2'd2) begin
            fails++; $display("FAIL win_no_ticks ticks=%0d state=%0d exp 0/2", ticks, M_STATE);
        end
        press();
        checks++;
        if (M_STATE !== 2'd0 || SCORE !== 4'd3) begin
            fails++; $display("FAIL win_to_idle state=%0d score=%0d exp 0/3", M_STATE, SCORE);
        end
        ticks = 0;
        for (int i = 0; i < 20; i++) begin cycle(); if (MOVE_TICK === 1'b1) ticks++; end
        checks++;
        if (ticks != 0) begin
            fails++; $display("FAIL idle_no_ticks got %0d exp 0", ticks);
        end
        press();
        checks++;
        if (M_STATE !== 2'd1 || SCORE !== 4'd0 || TARGET_REQ !== 1'b1) begin
            fails++; $display("FAIL replay state=%0d score=%0d req=%0b exp 1/0/1", M_STATE, SCORE, TARGET_REQ);
        end
    endtask

    task automatic test_simultaneous();
        int ticks;
        TARGET_ACK = 1'b1; cycle(); TARGET_ACK = 1'b0;
        REACHED = 1'b1; cycle(); REACHED = 1'b0;
        TARGET_ACK = 1'b1; cycle(); TARGET_ACK = 1'b0;
        HIT = 1'b1; REACHED = 1'b1;
        cycle();
        HIT = 1'b0; REACHED = 1'b0;
        checks++;
        if (M_STATE !== 2'd3 || SCORE !== 4'd1 || TARGET_REQ !== 1'b0) begin
            fails++; $display("FAIL hit_priority state=%0d score=%0d req=%0b exp 3/1/0", M_STATE, SCORE, TARGET_REQ);
        end
        ticks = 0;
        for (int i = 0; i < 15; i++) begin cycle(); if (MOVE_TICK === 1'b1) ticks++; end
        checks++;
        if (ticks != 0) begin
            fails++; $display("FAIL lose_no_ticks got %0d exp 0", ticks);
        end
    endtask

    task automatic test_pending();
        press();
        cycle();
        TARGET_ACK = 1'b1; cycle(); TARGET_ACK = 1'b0;
        checks++;
        if (M_STATE !== 2'd0 || TARGET_REQ !== 1'b0) begin
            fails++; $display("FAIL idle_ack_ignored state=%0d req=%0b exp 0/0", M_STATE, TARGET_REQ);
        end
        press();
        REACHED = 1'b1; cycle(); REACHED = 1'b0;
        checks++;
        if (SCORE !== 4'd0 || TARGET_REQ !== 1'b1) begin
            fails++; $display("FAIL reached_while_pending score=%0d req=%0b exp 0/1", SCORE, TARGET_REQ);
        end
    endtask

    task automatic test_midgame_reset();
        RESET = 1'b1; cycle(); RESET = 1'b0;
        cycle();
        press();
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (M_STATE !== 2'd1 || TARGET_REQ !== 1'b1 || m_age != 5) begin
            fails++; $display("FAIL midgame_setup state=%0d req=%0b exp 1/1", M_STATE, TARGET_REQ);
        end
        RESET = 1'b1; cycle(); RESET = 1'b0;
        checks++;
        if ({M_STATE, SCORE, MOVE_TICK, TARGET_REQ} !== 8'h00) begin
            fails++; $display("FAIL midgame_reset got %h exp 00", {M_STATE, SCORE, MOVE_TICK, TARGET_REQ});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) START = ~START;
            REACHED    = ($urandom_range(0, 5) == 0);
            HIT        = ($urandom_range(0, 59) == 0);
            TARGET_ACK = ($urandom_range(0, 2) == 0);
            RESET      = ($urandom_range(0, 799) == 0);
            cycle();
            checks++;
            if ({M_STATE, SCORE, MOVE_TICK, TARGET_REQ} !== {2'(m_state), 4'(m_score), m_tick, m_req}) begin
                fails++;
                $display("FAIL random_cycle %0d state=%0d/%0d score=%0d/%0d tick=%0b/%0b req=%0b/%0b (got/exp)",
                         i, M_STATE, m_state, SCORE, m_score, MOVE_TICK, m_tick, TARGET_REQ, m_req);
            end
        end
        RESET = 1'b0; START = 1'b0; REACHED = 1'b0; HIT = 1'b0; TARGET_ACK = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tick_pacing();
        test_win();
        test_simultaneous();
        test_pending();
        test_midgame_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/snake_master_fsm.md
# snake_master_fsm

Top-level game sequencer for the snake design. Owns the master game state that drives `SnakeControl`'s `M_STATE` input, counts targets eaten, paces snake movement with a score-dependent move tick and requests new targets from the target generator. Consumes `REACHED`/`HIT` from `SnakeControl` and a debounced start button from the input layer.

## Interface
- `WIN_SCORE`, default 10: targets needed to win; must be in 1..15.
- `TICK_W`, default 24: width of move-tick counter and period arithmetic.
- `TICK_BASE`, default 5_000_000: clock cycles per move at score 0.
- `TICK_STEP`, default 250_000: period reduction per point scored.
- `TICK_MIN`, default 1_000_000: floor on move period; requires `TICK_MIN` ≥ 2 and `TICK_MIN` ≤ `TICK_BASE`.

Ports:
- `CLK` input 1: system clock; one clock domain.
- `RESET` input 1: synchronous, active-high reset.
- `START` input 1: debounced start/advance button, level.
- `REACHED` input 1: single-cycle pulse from `SnakeControl`; the head is on the target.
- `HIT` input 1: from `SnakeControl`; collision with self or wall, level or pulse.
- `TARGET_ACK` input 1: target generator has latched a new `TARGET_H`/`TARGET_V`.
- `M_STATE` output 2: 0 = IDLE, 1 = PLAY, 2 = WIN, 3 = LOSE.
- `SCORE` output 4: targets eaten this game.
- `MOVE_TICK` output 1: single-cycle strobe that advances the snake one cell.
- `TARGET_REQ` output 1: request for a new target, held until acknowledged.

## Operation
- **Reset values:** `M_STATE`=IDLE, `SCORE`=0, `MOVE_TICK`=0, `TARGET_REQ`=0, tick counter 0, start-edge register 1. Because the start-edge register resets to 1, holding `START` through reset does not start a game.
- **Start edge:** `start_rise` = `START` & !`START_prev`. `START_prev` is registered every cycle.
- **IDLE:**
  - On `start_rise`: go to PLAY, clear `SCORE`, set `TARGET_REQ`=1 to fetch the initial target.
  - `REACHED` and `HIT` are ignored.
- **PLAY, move tick:**
  - Tick counter increments every cycle.
  - When counter == period−1: `MOVE_TICK`=1 for one cycle and the counter returns to 0.
  - period = `TICK_BASE` − `SCORE`·`TICK_STEP`, clamped to `TICK_MIN` when the product is ≥ `TICK_BASE` − `TICK_MIN`.
  - Compute in `TICK_W`+4 bits; no wrap is allowed.
  - Period is recomputed from the current `SCORE`. If a score change lowers the period below the current count, the counter resets to 0 on the next cycle with no tick.
- **PLAY, target reached:**
  - Accepted only when `REACHED`=1 and `TARGET_REQ`=0. While a request is pending, `REACHED` is ignored.
  - `SCORE` increments.
  - If the new score == `WIN_SCORE`: go to WIN with no request.
  - Otherwise: set `TARGET_REQ`=1.
- **PLAY, hit:** `HIT`=1 moves to LOSE. `HIT` has priority over `REACHED` in the same cycle, and `SCORE` is not incremented.
- **Handshake:**
  - `TARGET_REQ` stays high until a cycle with `TARGET_ACK`=1; it clears on the following edge.
  - `TARGET_ACK` while `TARGET_REQ`=0 is ignored.
  - Leaving PLAY clears `TARGET_REQ`.
- **WIN / LOSE:**
  - `SCORE` is held for display.
  - Tick counter is held at 0 and `MOVE_TICK`=0.
  - On `start_rise`: go to IDLE. `SCORE` is cleared on the next IDLE→PLAY transition, not here.
- **Mid-operation reset:** `RESET` overrides every transition, including a pending request; all outputs return to reset values on the next edge.

## Timing
- All outputs are registered and update on the `CLK` rising edge after the causing input is sampled (1-cycle latency).
- IDLE→PLAY: `M_STATE`=1 and `TARGET_REQ`=1 appear on the same edge. The first `MOVE_TICK` comes period cycles after PLAY entry.
- `REACHED` sampled at edge n: `SCORE`+1 and `TARGET_REQ`=1 (or `M_STATE`=WIN) at edge n+1.
- `TARGET_ACK` sampled at edge n: `TARGET_REQ`=0 at edge n+1. The minimum request length is 1 cycle.
- `MOVE_TICK` is exactly one cycle wide. In steady state, consecutive ticks are exactly period cycles apart.

## Test plan
Parameters for all scenarios: `WIN_SCORE`=3, `TICK_BASE`=10, `TICK_STEP`=3, `TICK_MIN`=4.

- **Reset/start:** hold `START`=1 through reset, then release and press again → stays IDLE until the second press; then `M_STATE`=1 and `TARGET_REQ`=1 one cycle after the press. Ack after 3 cycles → `TARGET_REQ` drops the next cycle.
- **Tick pacing:**
  - At score 0, `MOVE_TICK` pulses every 10 cycles.
  - After 1 point, every 7 cycles.
  - After 2 points, every 4 cycles (the clamp floor, since 10−6 = 4).
  - No ticks in IDLE, WIN or LOSE.
- **Win:** three accepted `REACHED` pulses, each acked → `SCORE` 1, 2, 3, then `M_STATE`=2 with `TARGET_REQ`=0. A `START` press → IDLE with `SCORE` still 3; the next press → PLAY with `SCORE`=0.
- **Simultaneous events:** `HIT`=1 and `REACHED`=1 in the same cycle at score 1 → `M_STATE`=3, `SCORE`=1.
- **Pending request:** `REACHED` pulsed while `TARGET_REQ`=1 → `SCORE` unchanged. `TARGET_ACK` pulsed in IDLE → no effect.
- **Mid-game reset:** `RESET` asserted in PLAY with `TARGET_REQ`=1 and the counter at 5 → next cycle `M_STATE`=0, `SCORE`=0, `TARGET_REQ`=0, `MOVE_TICK`=0.
